// File: rtl/run_ctrl_pkg.sv
// Shared codes for the run controller: sequencer state codes, controller
// states, run modes and stop-cause codes.
package run_ctrl_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCHA = 3'd1;
    localparam logic [2:0] FETCHB = 3'd2;
    localparam logic [2:0] EXECA  = 3'd3;
    localparam logic [2:0] EXECB  = 3'd4;

    typedef enum logic [1:0] {
        C_IDLE,
        C_LAUNCH,
        C_ACTIVE
    } ctrl_state_t;

    typedef enum logic {
        MODE_RUN,
        MODE_STEP
    } run_mode_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_HALT = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_STOP = 2'd3;

    // Reason for a terminating EXECA; a halt instruction outranks a host stop.
    function automatic logic [1:0] end_cause(input logic halt_insn, input logic stop_seen);
        if (halt_insn)
            return CAUSE_HALT;
        if (stop_seen)
            return CAUSE_STOP;
        return CAUSE_STEP;
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module run_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clr)
            count_reg <= '0;
        else if (en && (count_reg != MAX))
            count_reg <= count_reg + 1'b1;
    end

    assign count = count_reg;

endmodule

// File: rtl/run_ctrl.sv
// Host run control for the tiny CPU: launches the sequencer, injects halts at
// EXECA, counts retired instructions and reports why execution ended.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic [2:0]       cs,
    input  logic             halt_insn,
    output logic             run,
    output logic             halt,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       stop_cause
);

    ctrl_state_t state_reg, state_next;
    run_mode_t   mode_reg, mode_next;
    logic        stop_pend_reg, stop_pend_next;
    logic        done_reg, done_next;
    logic [1:0]  cause_reg, cause_next;
    logic        run_reg;
    logic        busy_reg;
    logic        cnt_clr;
    logic        at_execa;

    assign at_execa = (cs == EXECA);

    // Outside EXECA, or when idle, the decoder's halt passes straight through.
    assign halt = halt_insn | (at_execa & busy_reg & ((mode_reg == MODE_STEP) | stop_pend_reg));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= C_IDLE;
            mode_reg      <= MODE_RUN;
            stop_pend_reg <= 1'b0;
            done_reg      <= 1'b0;
            cause_reg     <= CAUSE_NONE;
            run_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            stop_pend_reg <= stop_pend_next;
            done_reg      <= done_next;
            cause_reg     <= cause_next;
            run_reg       <= (state_next == C_LAUNCH);
            busy_reg      <= (state_next != C_IDLE);
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        stop_pend_next = stop_pend_reg;
        cause_next     = cause_reg;
        done_next      = 1'b0;
        cnt_clr        = 1'b0;
        case (state_reg)
            C_IDLE: begin
                if (start) begin
                    mode_next      = MODE_RUN;
                    cnt_clr        = 1'b1;
                    cause_next     = CAUSE_NONE;
                    stop_pend_next = 1'b0;
                    state_next     = C_LAUNCH;
                end else if (step) begin
                    mode_next      = MODE_STEP;
                    cause_next     = CAUSE_NONE;
                    stop_pend_next = 1'b0;
                    state_next     = C_LAUNCH;
                end
            end
            C_LAUNCH: begin
                if (stop)
                    stop_pend_next = 1'b1;
                if (cs == FETCHA)
                    state_next = C_ACTIVE;
            end
            C_ACTIVE: begin
                if (stop)
                    stop_pend_next = 1'b1;
                if (at_execa && halt) begin
                    // A stop arriving in the terminating EXECA still names the cause.
                    state_next     = C_IDLE;
                    done_next      = 1'b1;
                    stop_pend_next = 1'b0;
                    cause_next     = end_cause(halt_insn, stop_pend_reg | stop);
                end else if (cs == IDLE) begin
                    state_next     = C_IDLE;
                    done_next      = 1'b1;
                    stop_pend_next = 1'b0;
                    cause_next     = CAUSE_NONE;
                end
            end
            default: state_next = C_IDLE;
        endcase
    end

    run_ctrl_sat_counter #(
        .W(CNT_W)
    ) u_retired (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (at_execa & busy_reg),
        .count (retired)
    );

    assign run        = run_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign stop_cause = cause_reg;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: behavioural sequencer plus a timing/count model derived
// from instruction cadence (one EXECA every four cycles after launch).
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, step, stop, seq_rst;
    logic [2:0]  cs;
    logic        halt_insn;
    logic        run, halt, busy, done;
    logic [15:0] retired;
    logic [1:0]  stop_cause;
    logic        run2, halt2, busy2, done2;
    logic [1:0]  retired2;
    logic [1:0]  cause2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pc    = 0;
    int halt_pos = -1;
    int done_cnt = 0;
    int halt_exec_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    run_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
        .cs(cs), .halt_insn(halt_insn), .run(run), .halt(halt), .busy(busy),
        .done(done), .retired(retired), .stop_cause(stop_cause)
    );

    run_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .step(step), .stop(stop),
        .cs(cs), .halt_insn(halt_insn), .run(run2), .halt(halt2), .busy(busy2),
        .done(done2), .retired(retired2), .stop_cause(cause2)
    );

    // Standard sequencer: IDLE -> FETCHA -> FETCHB -> EXECA -> (IDLE on halt | EXECB -> FETCHA)
    always @(posedge clk) begin
        if (seq_rst) begin
            cs <= IDLE;
        end else begin
            case (cs)
                IDLE:    if (run) cs <= FETCHA;
                FETCHA:  cs <= FETCHB;
                FETCHB:  cs <= EXECA;
                EXECA: begin
                    pc <= pc + 1;
                    cs <= halt ? IDLE : EXECB;
                end
                EXECB:   cs <= FETCHA;
                default: cs <= IDLE;
            endcase
        end
    end

    assign halt_insn = (cs == EXECA) && (pc == halt_pos);

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if ((cs == EXECA) && halt) halt_exec_cnt <= halt_exec_cnt + 1;
    end

    // Pulse start/step for one cycle; t is the index of the edge that samples it.
    task automatic launch(input logic s, input logic p, output int t);
        @(posedge clk); #1;
        start = s;
        step  = p;
        @(posedge clk); #1;
        start = 1'b0;
        step  = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(input int max, output int dcyc);
        dcyc = -1;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    // Free run with halt at the k-th instruction (k<=0: none) and a stop pulse dly cycles after launch.
    task automatic run_with_stop(input int k, input int dly, output int t, output int dcyc);
        halt_pos = (k > 0) ? pc + k - 1 : -1;
        launch(1'b1, 1'b0, t);
        dcyc = -1;
        for (int c = 0; c < 200; c++) begin
            stop = (c == dly);
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; seq_rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0;
        halt_pos = -1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; seq_rst = 1'b0;
        @(negedge clk);
        total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b exp=0", run); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        total++; if (stop_cause !== CAUSE_NONE) begin bad++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
        total++; if (halt !== 1'b0 || halt2 !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b/%b exp=0", halt, halt2); end
        $display("txn reset checked");
    endtask

    task automatic test_run_halt();
        int t, d;
        halt_pos = pc + 3;
        launch(1'b1, 1'b0, t);
        @(negedge clk);
        total++; if (run !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL launch_run1 got=%b%b exp=11", run, busy); end
        @(negedge clk);
        total++; if (run !== 1'b1 || cs !== FETCHA) begin bad++; $display("FAIL launch_run2 got=%b cs=%0d exp=1 cs=1", run, cs); end
        @(negedge clk);
        total++; if (run !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL launch_drop got=%b%b exp=01", run, busy); end
        wait_done(40, d);
        total++; if (d !== t + 16) begin bad++; $display("FAIL run_done_cycle got=%0d exp=%0d", d, t + 16); end
        total++; if (retired !== 16'd4) begin bad++; $display("FAIL run_retired got=%0d exp=4", retired); end
        total++; if (stop_cause !== CAUSE_HALT) begin bad++; $display("FAIL run_cause got=%0d exp=1", stop_cause); end
        total++; if (busy !== 1'b0 || done2 !== 1'b1) begin bad++; $display("FAIL run_busy got=%b done2=%b exp=0 1", busy, done2); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL run_done_width got=%b exp=0", done); end
        $display("txn run_halt done=%0d retired=%0d cause=%0d", d - t, retired, stop_cause);
    endtask

    task automatic test_step();
        int t, d, h0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        halt_pos = -1;
        for (int i = 1; i <= 3; i++) begin
            h0 = halt_exec_cnt;
            launch(1'b0, 1'b1, t);
            wait_done(30, d);
            total++; if (d !== t + 4) begin bad++; $display("FAIL step_done_cycle got=%0d exp=%0d", d, t + 4); end
            total++; if (retired !== 16'(i)) begin bad++; $display("FAIL step_retired got=%0d exp=%0d", retired, i); end
            total++; if (stop_cause !== CAUSE_STEP) begin bad++; $display("FAIL step_cause got=%0d exp=2", stop_cause); end
            @(posedge clk); #1;
            total++; if (halt_exec_cnt - h0 !== 1) begin bad++; $display("FAIL step_halts got=%0d exp=1", halt_exec_cnt - h0); end
            $display("txn step %0d retired=%0d cause=%0d", i, retired, stop_cause);
        end
        // Stop arriving in the very EXECA that a step terminates.
        launch(1'b0, 1'b1, t);
        repeat (3) @(posedge clk);
        #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL step_stop_done got=%b exp=1", done); end
        total++; if (stop_cause !== CAUSE_STOP) begin bad++; $display("FAIL step_stop_cause got=%0d exp=3", stop_cause); end
        total++; if (retired !== 16'd4) begin bad++; $display("FAIL step_stop_retired got=%0d exp=4", retired); end
        $display("txn step+stop retired=%0d cause=%0d", retired, stop_cause);
    endtask

    task automatic test_stop();
        int t, d;
        run_with_stop(0, 6, t, d);
        total++; if (d !== t + 8) begin bad++; $display("FAIL stop_done_cycle got=%0d exp=%0d", d, t + 8); end
        total++; if (retired !== 16'd2) begin bad++; $display("FAIL stop_retired got=%0d exp=2", retired); end
        total++; if (stop_cause !== CAUSE_STOP) begin bad++; $display("FAIL stop_cause got=%0d exp=3", stop_cause); end
        $display("txn stop retired=%0d cause=%0d", retired, stop_cause);
    endtask

    task automatic test_start_step_together();
        int t, d;
        halt_pos = pc + 2;
        launch(1'b1, 1'b1, t);
        d = -1;
        for (int c = 0; c < 60; c++) begin
            step = (c == 5);
            @(negedge clk);
            if (done) begin
                d = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        step = 1'b0;
        total++; if (d !== t + 12) begin bad++; $display("FAIL both_done_cycle got=%0d exp=%0d", d, t + 12); end
        total++; if (retired !== 16'd3) begin bad++; $display("FAIL both_retired got=%0d exp=3", retired); end
        total++; if (stop_cause !== CAUSE_HALT) begin bad++; $display("FAIL both_cause got=%0d exp=1", stop_cause); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || run !== 1'b0) begin bad++; $display("FAIL both_no_queue got=%b%b exp=00", busy, run); end
        $display("txn start+step retired=%0d cause=%0d", retired, stop_cause);
    endtask

    task automatic test_saturate();
        int t, d;
        run_with_stop(7, -1, t, d);
        total++; if (retired !== 16'd7) begin bad++; $display("FAIL sat_wide got=%0d exp=7", retired); end
        total++; if (retired2 !== 2'd3) begin bad++; $display("FAIL sat_narrow got=%0d exp=3", retired2); end
        total++; if (done2 !== 1'b1 || cause2 !== CAUSE_HALT || busy2 !== 1'b0 || run2 !== 1'b0)
            begin bad++; $display("FAIL sat_narrow_end got=%b%0d%b%b exp=1100", done2, cause2, busy2, run2); end
        $display("txn saturate retired=%0d retired2=%0d", retired, retired2);
    endtask

    task automatic test_random();
        int t, d, k, dly, nstop, exp_r;
        logic [1:0] exp_c;
        for (int n = 0; n < 10; n++) begin
            k = int'($urandom_range(1, 6));
            dly = int'($urandom_range(0, 22));
            nstop = (dly + 5) / 4;
            exp_r = (k < nstop) ? k : nstop;
            exp_c = (k <= nstop) ? CAUSE_HALT : CAUSE_STOP;
            run_with_stop(k, dly, t, d);
            total++; if (retired !== 16'(exp_r)) begin bad++; $display("FAIL rnd_retired k=%0d dly=%0d got=%0d exp=%0d", k, dly, retired, exp_r); end
            total++; if (stop_cause !== exp_c) begin bad++; $display("FAIL rnd_cause k=%0d dly=%0d got=%0d exp=%0d", k, dly, stop_cause, exp_c); end
            total++; if (d !== t + 4 * exp_r) begin bad++; $display("FAIL rnd_done k=%0d dly=%0d got=%0d exp=%0d", k, dly, d - t, 4 * exp_r); end
            $display("txn random k=%0d dly=%0d retired=%0d cause=%0d", k, dly, retired, stop_cause);
        end
    endtask

    task automatic test_reset_active();
        int t, d0;
        halt_pos = -1;
        launch(1'b1, 1'b0, t);
        repeat (8) @(posedge clk);
        #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        total++; if (run !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin bad++; $display("FAIL rst_active_ctl got=%b%b%b exp=000", run, busy, done); end
        total++; if (retired !== 16'd0) begin bad++; $display("FAIL rst_active_retired got=%0d exp=0", retired); end
        @(posedge clk); #1;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL rst_active_nodone got=%0d exp=%0d", done_cnt, d0); end
        seq_rst = 1'b1;
        @(posedge clk); #1;
        seq_rst = 1'b0;
        $display("txn reset_active busy=%b retired=%0d", busy, retired);
    endtask

    task automatic test_abort();
        int t, d;
        halt_pos = -1;
        launch(1'b1, 1'b0, t);
        repeat (5) @(posedge clk);
        #1; seq_rst = 1'b1;
        @(posedge clk); #1; seq_rst = 1'b0;
        wait_done(10, d);
        total++; if (d !== t + 7) begin bad++; $display("FAIL abort_done_cycle got=%0d exp=%0d", d, t + 7); end
        total++; if (stop_cause !== CAUSE_NONE) begin bad++; $display("FAIL abort_cause got=%0d exp=0", stop_cause); end
        total++; if (retired !== 16'd1) begin bad++; $display("FAIL abort_retired got=%0d exp=1", retired); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b%b exp=00", busy, done); end
        $display("txn abort retired=%0d cause=%0d", retired, stop_cause);
    endtask

    initial begin
        test_reset();
        test_run_halt();
        test_step();
        test_stop();
        test_start_step_together();
        test_saturate();
        test_random();
        test_reset_active();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
